wave_i2s_sink: RTL



---
 rtl/wave_audio_pkg.sv | 14 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/wave_i2s_sink.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wave_audio_pkg.sv
// Shared types and defaults for the synth voice audio path.
package wave_audio_pkg;

    localparam int DEFAULT_DATA_W = 18;
    localparam int DEFAULT_SLOT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;

    typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through sample buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sample_fifo #(
    parameter int DATA_W     = 18,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full buffer is only honoured when a pop frees a slot on the same clk.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_CNT);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    // Advance the pointers; reset discards all buffered samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Sample storage needs no reset since the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/wave_i2s_sink.sv
// Receives samples over the ready/received handshake, buffers them and
// plays each one as a stereo I2S frame (same sample in both slots).
module wave_i2s_sink
    import wave_audio_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int BCLK_DIV   = 4,
    parameter int SLOT_W     = DEFAULT_SLOT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              received,
    output logic              full,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_W);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    hs_state_t         state;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;
    logic [DATA_W-1:0] fifo_dout;

    logic [DIV_W-1:0]  div_cnt;
    logic              div_term;
    logic              fall_tick;
    logic [BIT_W-1:0]  next_bit;
    logic              next_lr;
    logic              left_start;
    logic [DATA_W-1:0] frame_reg;
    logic [DATA_W-1:0] shift_reg;

    // One push per ready phase: only from IDLE, and never while the buffer is full.
    assign push = (state == IDLE) && ready && !fifo_full;
    assign full = (fifo_count == DEPTH_CNT);

    // next_bit holds the slot position the coming falling tick will present.
    assign div_term   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall_tick  = div_term && bclk;
    assign left_start = fall_tick && (next_bit == '0) && !next_lr;

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (left_start),
        .din   (data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Four-phase handshake toward the waveform generator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            received <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready && !fifo_full) begin
                        state    <= ACK;
                        received <= 1'b1;
                    end
                end
                ACK: begin
                    if (!ready) begin
                        state    <= IDLE;
                        received <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    received <= 1'b0;
                end
            endcase
        end
    end

    // Divide clk down to the bit clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_term) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Serializer: all I2S outputs move on the bclk falling tick; bit 0 of each slot is the I2S delay bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_bit  <= '0;
            next_lr   <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            frame_reg <= '0;
            shift_reg <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (fall_tick) begin
                next_bit <= (next_bit == BIT_W'(SLOT_W - 1)) ? '0 : next_bit + BIT_W'(1);
                if (next_bit == '0) begin
                    lrclk   <= next_lr;
                    next_lr <= ~next_lr;
                    sdata   <= 1'b0;
                    if (!next_lr) begin
                        frame_reg <= fifo_empty ? '0 : fifo_dout;
                        shift_reg <= fifo_empty ? '0 : fifo_dout;
                        underrun  <= fifo_empty;
                    end else begin
                        shift_reg <= frame_reg;
                    end
                end else begin
                    sdata     <= shift_reg[DATA_W-1];
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule
